// File: rtl/controlador_matriz_multicanal.sv
// Multiplexed bar-graph LED matrix driver: one column per channel, scanned with a
// blanking slot at the start of each column, frame-synchronous level updates and blinking alarms.
module controlador_matriz_multicanal #(
    parameter int NUM_LINHAS    = 7,
    parameter int NUM_COLUNAS   = 4,
    parameter int NIVEL_W       = 3,
    parameter int SCAN_DIV      = 1000,
    parameter int PISCA_QUADROS = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           habilita,
    input  logic [NUM_COLUNAS*NIVEL_W-1:0] niveis,
    input  logic                           atualiza,
    input  logic [NIVEL_W-1:0]             limiar_critico,
    output logic [NUM_LINHAS-1:0]          linhas_matriz,
    output logic [NUM_COLUNAS-1:0]         colunas_matriz,
    output logic                           quadro_fim
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int COL_W = (NUM_COLUNAS > 1) ? $clog2(NUM_COLUNAS) : 1;
    localparam int QDR_W = (PISCA_QUADROS > 1) ? $clog2(PISCA_QUADROS) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(NUM_COLUNAS - 1);
    localparam logic [QDR_W-1:0] QDR_MAX = QDR_W'(PISCA_QUADROS - 1);

    logic [DIV_W-1:0]             r_div;
    logic [COL_W-1:0]             r_col;
    logic [QDR_W-1:0]             r_quadros;
    logic                         r_fase;
    logic                         r_pend_flag;
    logic [NUM_COLUNAS*NIVEL_W-1:0] r_pend;
    logic [NUM_COLUNAS*NIVEL_W-1:0] r_exib;

    logic                  w_fim_slot;
    logic                  w_wrap;
    logic [NIVEL_W-1:0]    w_nivel;
    logic                  w_critico;
    int                    w_acesas;
    logic [NUM_LINHAS-1:0] w_barra;

    assign w_fim_slot = (r_div == DIV_MAX);
    assign w_wrap     = habilita && w_fim_slot && (r_col == COL_MAX);

    always_comb begin
        w_nivel = '0;
        for (int c = 0; c < NUM_COLUNAS; c++) begin
            if (r_col == COL_W'(c)) begin
                w_nivel = r_exib[c*NIVEL_W +: NIVEL_W];
            end
        end
    end

    // Bottom row is the MSB, so a bar of n lit rows clears the top n bit positions.
    always_comb begin
        w_acesas = (int'(w_nivel) > NUM_LINHAS) ? NUM_LINHAS : int'(w_nivel);
        w_barra  = '1;
        for (int r = 0; r < NUM_LINHAS; r++) begin
            if (r >= NUM_LINHAS - w_acesas) begin
                w_barra[r] = 1'b0;
            end
        end
    end

    assign w_critico = r_fase && (w_nivel < limiar_critico);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div       <= '0;
            r_col       <= '0;
            r_quadros   <= '0;
            r_fase      <= 1'b0;
            r_pend_flag <= 1'b0;
            r_pend      <= '0;
            r_exib      <= '0;
        end else begin
            if (atualiza) begin
                r_pend      <= niveis;
                r_pend_flag <= 1'b1;
            end
            if (habilita) begin
                if (w_fim_slot) begin
                    r_div <= '0;
                    r_col <= (r_col == COL_MAX) ? '0 : r_col + 1'b1;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end
            // A strobe landing on the wrap itself bypasses the buffer so it is not lost for a frame.
            if (w_wrap) begin
                if (atualiza) begin
                    r_exib <= niveis;
                end else if (r_pend_flag) begin
                    r_exib <= r_pend;
                end
                r_pend_flag <= 1'b0;
                if (r_quadros == QDR_MAX) begin
                    r_quadros <= '0;
                    r_fase    <= ~r_fase;
                end else begin
                    r_quadros <= r_quadros + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !habilita) begin
            colunas_matriz <= '0;
            linhas_matriz  <= '1;
            quadro_fim     <= 1'b0;
        end else begin
            quadro_fim <= w_wrap;
            if (r_div == '0) begin
                colunas_matriz <= '0;
                linhas_matriz  <= '1;
            end else begin
                colunas_matriz <= NUM_COLUNAS'(1) << r_col;
                linhas_matriz  <= w_critico ? '1 : w_barra;
            end
        end
    end

endmodule
